// File: rtl/non_res_div_param_if.sv
// Operand/result bus bundle for non_res_div_param.
//   begin_div : start request (master -> slave)
//   in_bus    : operand bus, dividend hi, dividend lo, divisor (master -> slave)
//   fin       : result strobe, quotient cycle then remainder cycle (slave -> master)
//   out_bus   : quotient, then remainder, 0 otherwise (slave -> master)
//   busy      : operation in flight (slave -> master)
//   err_div0  : divisor was zero (slave -> master)
//   err_ovf   : quotient does not fit in BUS_W bits (slave -> master)
interface non_res_div_param_if #(
    parameter int BUS_W = 8
);
    logic             begin_div;
    logic [BUS_W-1:0] in_bus;
    logic             fin;
    logic [BUS_W-1:0] out_bus;
    logic             busy;
    logic             err_div0;
    logic             err_ovf;

    modport master (
        output begin_div, in_bus,
        input  fin, out_bus, busy, err_div0, err_ovf
    );

    modport slave (
        input  begin_div, in_bus,
        output fin, out_bus, busy, err_div0, err_ovf
    );
endinterface

// File: rtl/non_res_div_param.sv
// Multi-cycle unsigned non-restoring divider: 2*BUS_W-bit dividend divided by a
// BUS_W-bit divisor. Operands arrive serially on in_bus (dividend high word,
// dividend low word, divisor); quotient then remainder leave serially on out_bus
// with fin high for both cycles. Divide-by-zero and quotient overflow are
// flagged and return quotient = all ones, remainder = dividend low word.
//   clk : system clock, rising edge
//   rst : asynchronous active-low reset
//   dif : slave side of non_res_div_param_if (begin_div, in_bus, fin,
//         out_bus, busy, err_div0, err_ovf)
module non_res_div_param #(
    parameter  int BUS_W = 8,
    localparam int CNT_W = $clog2(BUS_W + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    non_res_div_param_if.slave    dif
);

    typedef enum logic [3:0] {
        IDLE,
        LOAD_HI,
        LOAD_LO,
        LOAD_DIV,
        CHECK,
        CALC,
        CORR,
        OUT_Q,
        OUT_R
    } state_t;

    state_t                   r_state;
    logic signed [BUS_W:0]    r_p;      // partial remainder
    logic        [BUS_W-1:0]  r_q;      // dividend low word, becomes quotient
    logic        [BUS_W-1:0]  r_div;
    logic        [CNT_W-1:0]  r_cnt;
    logic                     r_fin;
    logic        [BUS_W-1:0]  r_out;
    logic                     r_busy;
    logic                     r_err_div0;
    logic                     r_err_ovf;

    logic signed [BUS_W:0]    w_p_step;
    logic        [BUS_W-1:0]  w_q_step;
    logic signed [BUS_W:0]    w_p_rest;

    // One non-restoring iteration on the shifted partial remainder. The shifted
    // value can exceed the W+1-bit signed range, but the add/subtract result
    // always lies in [-divisor, divisor), so wrap-around arithmetic is exact.
    function automatic logic signed [BUS_W:0] nr_step(
        input logic signed [BUS_W:0]  p,
        input logic                   q_msb,
        input logic        [BUS_W-1:0] dv
    );
        logic signed [BUS_W:0] sh;
        logic signed [BUS_W:0] de;
        sh = {p[BUS_W-1:0], q_msb};
        de = {1'b0, dv};
        return p[BUS_W] ? (sh + de) : (sh - de);
    endfunction

    // Final restore: a negative remainder is pulled back into [0, divisor).
    function automatic logic signed [BUS_W:0] nr_restore(
        input logic signed [BUS_W:0]  p,
        input logic        [BUS_W-1:0] dv
    );
        logic signed [BUS_W:0] de;
        de = {1'b0, dv};
        return p[BUS_W] ? (p + de) : p;
    endfunction

    always_comb begin
        w_p_step = nr_step(r_p, r_q[BUS_W-1], r_div);
        w_q_step = {r_q[BUS_W-2:0], ~w_p_step[BUS_W]};
        w_p_rest = nr_restore(r_p, r_div);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_p        <= '0;
            r_q        <= '0;
            r_div      <= '0;
            r_cnt      <= '0;
            r_fin      <= 1'b0;
            r_out      <= '0;
            r_busy     <= 1'b0;
            r_err_div0 <= 1'b0;
            r_err_ovf  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_fin <= 1'b0;
                    r_out <= '0;
                    if (dif.begin_div) begin
                        r_err_div0 <= 1'b0;
                        r_err_ovf  <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= LOAD_HI;
                    end
                end
                LOAD_HI: begin
                    r_p     <= {1'b0, dif.in_bus};
                    r_state <= LOAD_LO;
                end
                LOAD_LO: begin
                    r_q     <= dif.in_bus;
                    r_state <= LOAD_DIV;
                end
                LOAD_DIV: begin
                    r_div   <= dif.in_bus;
                    r_state <= CHECK;
                end
                CHECK: begin
                    if ((r_div == '0) || (r_p[BUS_W-1:0] >= r_div)) begin
                        // Error result: park the low word as the remainder so
                        // OUT_Q can treat both paths the same way.
                        r_err_div0 <= (r_div == '0);
                        r_err_ovf  <= (r_div != '0);
                        r_p        <= {1'b0, r_q};
                        r_q        <= '1;
                        r_fin      <= 1'b1;
                        r_out      <= '1;
                        r_state    <= OUT_Q;
                    end else begin
                        r_cnt   <= CNT_W'(BUS_W);
                        r_state <= CALC;
                    end
                end
                CALC: begin
                    r_p   <= w_p_step;
                    r_q   <= w_q_step;
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        r_state <= CORR;
                    end
                end
                CORR: begin
                    r_p     <= w_p_rest;
                    r_fin   <= 1'b1;
                    r_out   <= r_q;
                    r_state <= OUT_Q;
                end
                OUT_Q: begin
                    r_fin   <= 1'b1;
                    r_out   <= r_p[BUS_W-1:0];
                    r_state <= OUT_R;
                end
                OUT_R: begin
                    r_fin   <= 1'b0;
                    r_out   <= '0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_fin   <= 1'b0;
                    r_out   <= '0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign dif.fin      = r_fin;
    assign dif.out_bus  = r_out;
    assign dif.busy     = r_busy;
    assign dif.err_div0 = r_err_div0;
    assign dif.err_ovf  = r_err_ovf;

endmodule

// File: tb/tb_non_res_div_param.sv
module tb_non_res_div_param;

    logic clk;
    logic rst;

    int n_chk;
    int n_pass;

    non_res_div_param_if #(.BUS_W(8))  if8 ();
    non_res_div_param_if #(.BUS_W(16)) if16 ();

    non_res_div_param #(.BUS_W(8)) u_div8 (
        .clk (clk),
        .rst (rst),
        .dif (if8)
    );

    non_res_div_param #(.BUS_W(16)) u_div16 (
        .clk (clk),
        .rst (rst),
        .dif (if16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Behavioural reference: plain integer division of the concatenated dividend.
    function automatic void ref_div(input int w, input logic [31:0] hi, input logic [31:0] lo,
                                    input logic [31:0] d, output logic [31:0] q,
                                    output logic [31:0] r, output logic e0, output logic eo);
        longint unsigned num;
        longint unsigned mask;
        mask = (longint'(1) << w) - 1;
        num  = ({32'b0, hi} << w) | {32'b0, lo};
        e0 = 1'b0;
        eo = 1'b0;
        if (d == 0) begin
            e0 = 1'b1;
            q  = 32'(mask);
            r  = lo;
        end else if (hi >= d) begin
            eo = 1'b1;
            q  = 32'(mask);
            r  = lo;
        end else begin
            q = 32'((num / {32'b0, d}) & mask);
            r = 32'(num % {32'b0, d});
        end
    endfunction

    task automatic set_begin(input bit s16, input logic b);
        if (s16) if16.begin_div = b;
        else     if8.begin_div  = b;
    endtask

    task automatic set_bus(input bit s16, input logic [31:0] v);
        if (s16) if16.in_bus = v[15:0];
        else     if8.in_bus  = v[7:0];
    endtask

    function automatic logic [31:0] o_bus(input bit s16);
        return s16 ? 32'(if16.out_bus) : 32'(if8.out_bus);
    endfunction
    function automatic logic o_fin(input bit s16);
        return s16 ? if16.fin : if8.fin;
    endfunction
    function automatic logic o_busy(input bit s16);
        return s16 ? if16.busy : if8.busy;
    endfunction
    function automatic logic [1:0] o_err(input bit s16);
        return s16 ? {if16.err_div0, if16.err_ovf} : {if8.err_div0, if8.err_ovf};
    endfunction

    // Runs one division. Call at a negedge with the DUT idle.
    // hold: keep begin_div high throughout; pulse_at: pulse begin_div after that edge;
    // abort_at: pull reset after that edge and check the abort.
    task automatic run(input bit s16, input logic [31:0] hi, input logic [31:0] lo,
                       input logic [31:0] d, input bit hold, input int pulse_at,
                       input int abort_at);
        int          w;
        int          lat;
        int          exp_lat;
        bit          got;
        logic [31:0] q, r;
        logic        e0, eo;
        w = s16 ? 16 : 8;
        ref_div(w, hi, lo, d, q, r, e0, eo);
        exp_lat = (e0 || eo) ? 4 : 5 + w;

        set_begin(s16, 1'b1);
        @(posedge clk); #1;                       // E0
        set_begin(s16, hold);
        set_bus(s16, hi);
        @(negedge clk);
        chk("busy_after_E0", 32'(o_busy(s16)), 32'd1);
        chk("err_clr_E0", 32'(o_err(s16)), 32'd0);
        @(posedge clk); #1; set_bus(s16, lo);     // E1
        @(posedge clk); #1; set_bus(s16, d);      // E2
        @(posedge clk); #1; set_bus(s16, $urandom); // E3
        lat = 3;
        got = 1'b0;
        while (lat < 100 && !got) begin
            @(posedge clk);
            lat++;
            #1;
            if (pulse_at == lat)   set_begin(s16, 1'b1);
            else if (!hold)        set_begin(s16, 1'b0);
            if (abort_at == lat) begin
                chk("busy_pre_abort", 32'(o_busy(s16)), 32'd1);
                rst = 1'b0;
                #1;
                chk("abort_fin", 32'(o_fin(s16)), 32'd0);
                chk("abort_busy", 32'(o_busy(s16)), 32'd0);
                chk("abort_out", o_bus(s16), 32'd0);
                @(negedge clk);
                rst = 1'b1;
                return;
            end
            @(negedge clk);
            if (o_fin(s16)) got = 1'b1;
        end
        if (!got) begin
            chk("fin_timeout", 32'd0, 32'd1);
            return;
        end
        chk("latency", 32'(lat), 32'(exp_lat));
        chk("quotient", o_bus(s16), q);
        chk("err_flags", 32'(o_err(s16)), {30'd0, e0, eo});
        chk("busy_outq", 32'(o_busy(s16)), 32'd1);
        @(negedge clk);
        chk("fin_outr", 32'(o_fin(s16)), 32'd1);
        chk("remainder", o_bus(s16), r);
        @(negedge clk);
        chk("fin_idle", 32'(o_fin(s16)), 32'd0);
        chk("busy_idle", 32'(o_busy(s16)), 32'd0);
        chk("out_idle", o_bus(s16), 32'd0);
        chk("err_held", 32'(o_err(s16)), {30'd0, e0, eo});
    endtask

    initial begin
        logic [31:0] hi, lo, d, mask;
        bit          s16;
        n_chk  = 0;
        n_pass = 0;
        rst = 1'b0;
        if8.begin_div  = 1'b0;
        if8.in_bus     = '0;
        if16.begin_div = 1'b0;
        if16.in_bus    = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_fin8", 32'(if8.fin), 32'd0);
        chk("rst_out8", 32'(if8.out_bus), 32'd0);
        chk("rst_busy8", 32'(if8.busy), 32'd0);
        chk("rst_err8", 32'({if8.err_div0, if8.err_ovf}), 32'd0);
        chk("rst_out16", 32'(if16.out_bus), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Directed cases
        run(1'b0, 32'h00, 32'hEE, 32'h0B, 1'b0, 0, 0);   // 0x15 r 0x07
        run(1'b0, 32'h12, 32'h34, 32'h00, 1'b0, 0, 0);   // div by zero
        run(1'b0, 32'h0B, 32'h00, 32'h0B, 1'b0, 0, 0);   // overflow at hi == divisor
        run(1'b0, 32'h0A, 32'hFF, 32'h0B, 1'b0, 0, 0);   // largest quotient
        run(1'b0, 32'h03, 32'h21, 32'h09, 1'b0, 7, 0);   // begin_div pulsed in CALC
        run(1'b0, 32'h05, 32'h77, 32'hC8, 1'b1, 0, 0);   // begin_div held high
        run(1'b0, 32'h00, 32'h64, 32'h07, 1'b1, 0, 0);   // accepted right after OUT_R
        set_begin(1'b0, 1'b0);
        @(negedge clk);
        chk("idle_after_hold", 32'(if8.busy), 32'd0);
        run(1'b0, 32'h01, 32'h02, 32'h30, 1'b0, 0, 8);   // reset mid-CALC
        run(1'b0, 32'h00, 32'h64, 32'h07, 1'b0, 0, 0);   // 0x0E r 0x02
        run(1'b1, 32'h0001, 32'h2345, 32'h0100, 1'b0, 0, 0);
        run(1'b1, 32'h00FF, 32'hFFFF, 32'h0100, 1'b0, 0, 0);

        // Randomized operations
        for (int i = 0; i < 40; i++) begin
            s16  = (i % 4 == 3);
            mask = s16 ? 32'h0000_FFFF : 32'h0000_00FF;
            d    = $urandom & mask;
            if (i % 9 == 0) d = 0;
            lo   = $urandom & mask;
            if (i % 5 == 0 || d == 0) hi = $urandom & mask;
            else                      hi = $urandom % d;
            run(s16, hi, lo, d, 1'b0, 0, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
